ball_ctrl: RTL and testbench



---
 rtl/ball_ctrl_pkg.sv | 38 +++
 rtl/ball_collide.sv | 104 ++++++++++
 rtl/ball_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ball_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ball_ctrl_pkg.sv
// Shared pong definitions: geometry defaults, FSM state and direction/scorer types.
package ball_ctrl_pkg;

    localparam int unsigned PONG_H_RES        = 640;
    localparam int unsigned PONG_V_RES        = 480;
    localparam int unsigned PONG_X_W          = 10;
    localparam int unsigned PONG_Y_W          = 10;
    localparam int unsigned PONG_BALL_SIDE    = 8;
    localparam int unsigned PONG_PADDLE_W     = 8;
    localparam int unsigned PONG_PADDLE_H     = 64;
    localparam int unsigned PONG_SPEED        = 4;
    localparam int unsigned PONG_SERVE_FRAMES = 60;
    localparam int unsigned PONG_SCORE_MAX    = 9;

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StPoint,
        StOver
    } state_e;

    typedef enum logic {
        DirLeft  = 1'b0,
        DirRight = 1'b1
    } dir_x_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_y_e;

    typedef enum logic {
        ScorerPlayer = 1'b0,
        ScorerPc     = 1'b1
    } scorer_e;

endpackage

// File: rtl/ball_collide.sv
// Combinational one-frame ball step: wall bounces, paddle hits and score detection.
module ball_collide
    import ball_ctrl_pkg::*;
#(
    parameter int unsigned H_RES     = PONG_H_RES,
    parameter int unsigned V_RES     = PONG_V_RES,
    parameter int unsigned X_W       = PONG_X_W,
    parameter int unsigned Y_W       = PONG_Y_W,
    parameter int unsigned BALL_SIDE = PONG_BALL_SIDE,
    parameter int unsigned PADDLE_W  = PONG_PADDLE_W,
    parameter int unsigned PADDLE_H  = PONG_PADDLE_H,
    parameter int unsigned SPEED     = PONG_SPEED
) (
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  dir_x_e         i_dx,
    input  dir_y_e         i_dy,
    input  logic [X_W-1:0] i_pp_x,
    input  logic [Y_W-1:0] i_pp_y,
    input  logic [X_W-1:0] i_pc_x,
    input  logic [Y_W-1:0] i_pc_y,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output dir_x_e         o_dx,
    output dir_y_e         o_dy,
    output logic           o_score,
    output scorer_e        o_scorer
);

    localparam logic [X_W:0] XSpeed = (X_W+1)'(SPEED);
    localparam logic [X_W:0] XSide  = (X_W+1)'(BALL_SIDE);
    localparam logic [X_W:0] XRes   = (X_W+1)'(H_RES);
    localparam logic [X_W:0] XPadW  = (X_W+1)'(PADDLE_W);
    localparam logic [Y_W:0] YSpeed = (Y_W+1)'(SPEED);
    localparam logic [Y_W:0] YSide  = (Y_W+1)'(BALL_SIDE);
    localparam logic [Y_W:0] YRes   = (Y_W+1)'(V_RES);
    localparam logic [Y_W:0] YPadH  = (Y_W+1)'(PADDLE_H);

    logic [X_W:0] w_x, w_nx, w_pp_x, w_pc_x;
    logic [Y_W:0] w_y, w_ny, w_pp_y, w_pc_y;
    logic         w_hit;

    // One extra bit of headroom so sums near the screen edge never wrap.
    always_comb begin
        w_x      = {1'b0, i_x};
        w_y      = {1'b0, i_y};
        w_pp_x   = {1'b0, i_pp_x};
        w_pp_y   = {1'b0, i_pp_y};
        w_pc_x   = {1'b0, i_pc_x};
        w_pc_y   = {1'b0, i_pc_y};
        w_ny     = w_y;
        w_nx     = w_x;
        w_hit    = 1'b0;
        o_dx     = i_dx;
        o_dy     = i_dy;
        o_score  = 1'b0;
        o_scorer = ScorerPlayer;

        if (i_dy == DirDown) begin
            if (w_y + YSpeed + YSide >= YRes) begin
                w_ny = YRes - YSide;
                o_dy = DirUp;
            end else begin
                w_ny = w_y + YSpeed;
            end
        end else begin
            if (w_y < YSpeed) begin
                w_ny = '0;
                o_dy = DirDown;
            end else begin
                w_ny = w_y - YSpeed;
            end
        end

        if (i_dx == DirLeft) begin
            w_nx  = (w_x < XSpeed) ? '0 : w_x - XSpeed;
            w_hit = (w_nx <= w_pp_x + XPadW) && (w_nx + XSide > w_pp_x) &&
                    (w_ny + YSide > w_pp_y) && (w_ny < w_pp_y + YPadH);
            if (w_hit) begin
                w_nx = w_pp_x + XPadW;
                o_dx = DirRight;
            end else if (w_nx == '0) begin
                o_score  = 1'b1;
                o_scorer = ScorerPc;
            end
        end else begin
            w_nx  = w_x + XSpeed;
            w_hit = (w_nx + XSide >= w_pc_x) && (w_nx < w_pc_x + XPadW) &&
                    (w_ny + YSide > w_pc_y) && (w_ny < w_pc_y + YPadH);
            if (w_hit) begin
                w_nx = w_pc_x - XSide;
                o_dx = DirLeft;
            end else if (w_nx + XSide >= XRes) begin
                w_nx     = XRes - XSide;
                o_score  = 1'b1;
                o_scorer = ScorerPlayer;
            end
        end

        o_x = w_nx[X_W-1:0];
        o_y = w_ny[Y_W-1:0];
    end

endmodule

// File: rtl/ball_ctrl.sv
// Pong game sequencer: serve/play/point/over FSM, frame-gated ball motion and scoring.
module ball_ctrl
    import ball_ctrl_pkg::*;
#(
    parameter int unsigned H_RES        = PONG_H_RES,
    parameter int unsigned V_RES        = PONG_V_RES,
    parameter int unsigned X_W          = PONG_X_W,
    parameter int unsigned Y_W          = PONG_Y_W,
    parameter int unsigned BALL_SIDE    = PONG_BALL_SIDE,
    parameter int unsigned PADDLE_W     = PONG_PADDLE_W,
    parameter int unsigned PADDLE_H     = PONG_PADDLE_H,
    parameter int unsigned SPEED        = PONG_SPEED,
    parameter int unsigned SERVE_FRAMES = PONG_SERVE_FRAMES,
    parameter int unsigned SCORE_MAX    = PONG_SCORE_MAX
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           new_frame_i,
    input  logic           start_i,
    input  logic [X_W-1:0] player_paddle_x_i,
    input  logic [Y_W-1:0] player_paddle_y_i,
    input  logic [X_W-1:0] pc_paddle_x_i,
    input  logic [Y_W-1:0] pc_paddle_y_i,
    output logic [X_W-1:0] ball_x_o,
    output logic [Y_W-1:0] ball_y_o,
    output logic [3:0]     player_score_o,
    output logic [3:0]     pc_score_o,
    output logic           point_o,
    output logic           game_over_o
);

    localparam int unsigned    CntW     = $clog2(SERVE_FRAMES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(SERVE_FRAMES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [X_W-1:0] XCentre  = X_W'(H_RES / 2 - BALL_SIDE / 2);
    localparam logic [Y_W-1:0] YCentre  = Y_W'(V_RES / 2 - BALL_SIDE / 2);
    localparam logic [3:0]     ScoreMax = 4'(SCORE_MAX);

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [X_W-1:0]  r_x;
    logic [Y_W-1:0]  r_y;
    dir_x_e          r_dx;
    dir_y_e          r_dy;
    logic [3:0]      r_ps;
    logic [3:0]      r_pcs;
    logic            r_point;
    logic            r_over;
    scorer_e         r_scorer;

    logic [X_W-1:0]  w_nx;
    logic [Y_W-1:0]  w_ny;
    dir_x_e          w_ndx;
    dir_y_e          w_ndy;
    logic            w_score;
    scorer_e         w_scorer;
    logic [3:0]      w_cur_score;
    logic [3:0]      w_inc_score;

    ball_collide #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .BALL_SIDE (BALL_SIDE),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H),
        .SPEED     (SPEED)
    ) u_collide (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .i_pp_x   (player_paddle_x_i),
        .i_pp_y   (player_paddle_y_i),
        .i_pc_x   (pc_paddle_x_i),
        .i_pc_y   (pc_paddle_y_i),
        .o_x      (w_nx),
        .o_y      (w_ny),
        .o_dx     (w_ndx),
        .o_dy     (w_ndy),
        .o_score  (w_score),
        .o_scorer (w_scorer)
    );

    always_comb begin
        w_cur_score = (r_scorer == ScorerPc) ? r_pcs : r_ps;
        w_inc_score = (w_cur_score >= ScoreMax) ? ScoreMax : w_cur_score + 4'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_x      <= XCentre;
            r_y      <= YCentre;
            r_dx     <= DirLeft;
            r_dy     <= DirDown;
            r_ps     <= '0;
            r_pcs    <= '0;
            r_point  <= 1'b0;
            r_over   <= 1'b0;
            r_scorer <= ScorerPlayer;
        end else begin
            r_point <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (new_frame_i && start_i) begin
                        r_cnt   <= CntLoad;
                        r_state <= StServe;
                    end
                end
                StServe: begin
                    // The frame that finds the counter empty only switches to play.
                    if (new_frame_i) begin
                        if (r_cnt == '0) begin
                            r_state <= StPlay;
                        end else begin
                            r_cnt <= r_cnt - CntOne;
                        end
                    end
                end
                StPlay: begin
                    if (new_frame_i) begin
                        r_x  <= w_nx;
                        r_y  <= w_ny;
                        r_dx <= w_ndx;
                        r_dy <= w_ndy;
                        if (w_score) begin
                            r_scorer <= w_scorer;
                            r_point  <= 1'b1;
                            r_state  <= StPoint;
                        end
                    end
                end
                StPoint: begin
                    if (r_scorer == ScorerPc) begin
                        r_pcs <= w_inc_score;
                    end else begin
                        r_ps <= w_inc_score;
                    end
                    r_x <= XCentre;
                    r_y <= YCentre;
                    if (w_inc_score == ScoreMax) begin
                        r_over  <= 1'b1;
                        r_state <= StOver;
                    end else begin
                        // Serve toward the side that just conceded.
                        r_dx    <= (r_scorer == ScorerPc) ? DirLeft : DirRight;
                        r_cnt   <= CntLoad;
                        r_state <= StServe;
                    end
                end
                StOver: begin
                    if (new_frame_i && start_i) begin
                        r_ps    <= '0;
                        r_pcs   <= '0;
                        r_dx    <= DirLeft;
                        r_cnt   <= CntLoad;
                        r_over  <= 1'b0;
                        r_state <= StServe;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ball_x_o       = r_x;
    assign ball_y_o       = r_y;
    assign player_score_o = r_ps;
    assign pc_score_o     = r_pcs;
    assign point_o        = r_point;
    assign game_over_o    = r_over;

endmodule

// File: tb/tb_ball_ctrl.sv
// Scoreboard bench for ball_ctrl: directed game sequences with hand-computed ball positions.
module tb_ball_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic       new_frame_i;
    logic       start_i;
    logic [9:0] player_paddle_x_i;
    logic [9:0] player_paddle_y_i;
    logic [9:0] pc_paddle_x_i;
    logic [9:0] pc_paddle_y_i;
    logic [9:0] ball_x_o;
    logic [9:0] ball_y_o;
    logic [3:0] player_score_o;
    logic [3:0] pc_score_o;
    logic       point_o;
    logic       game_over_o;

    ball_ctrl u_dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .new_frame_i       (new_frame_i),
        .start_i           (start_i),
        .player_paddle_x_i (player_paddle_x_i),
        .player_paddle_y_i (player_paddle_y_i),
        .pc_paddle_x_i     (pc_paddle_x_i),
        .pc_paddle_y_i     (pc_paddle_y_i),
        .ball_x_o          (ball_x_o),
        .ball_y_o          (ball_y_o),
        .player_score_o    (player_score_o),
        .pc_score_o        (pc_score_o),
        .point_o           (point_o),
        .game_over_o       (game_over_o)
    );

    typedef struct {
        int    frame;
        string name;
        int    x;
        int    y;
        int    ps;
        int    pcs;
        int    go;
    } exp_t;

    exp_t frame_q[$];
    exp_t point_q[$];
    exp_t now_q[$];
    event ev_probe;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   fnum      = 0;
    int   mon_frame = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_all(input exp_t e);
        cmp({e.name, " ball_x"}, int'(ball_x_o), e.x);
        cmp({e.name, " ball_y"}, int'(ball_y_o), e.y);
        cmp({e.name, " player_score"}, int'(player_score_o), e.ps);
        cmp({e.name, " pc_score"}, int'(pc_score_o), e.pcs);
        cmp({e.name, " game_over"}, int'(game_over_o), e.go);
    endtask

    function automatic exp_t mk(input string name, input int x, input int y, input int ps,
                                input int pcs, input int go);
        exp_t e;
        e.frame = fnum + 1;
        e.name  = name;
        e.x     = x;
        e.y     = y;
        e.ps    = ps;
        e.pcs   = pcs;
        e.go    = go;
        return e;
    endfunction

    // Frame monitor: outputs are checked on the falling edge after each frame pulse.
    initial forever begin
        @(posedge clk_i);
        if (new_frame_i && !rst_i) begin
            exp_t e;
            mon_frame++;
            @(negedge clk_i);
            while (frame_q.size() > 0 && frame_q[0].frame <= mon_frame) begin
                e = frame_q.pop_front();
                cmp_all(e);
            end
        end
    end

    // Point monitor: pulse position, one-cycle width, then updated scores and recentred ball.
    initial forever begin
        @(negedge clk_i);
        if (point_o === 1'b1) begin
            exp_t e;
            if (point_q.size() == 0) begin
                cmp("unexpected point_o", int'(point_o), 0);
            end else begin
                e = point_q.pop_front();
                cmp({e.name, " ball_x at point"}, int'(ball_x_o), e.x);
                cmp({e.name, " ball_y at point"}, int'(ball_y_o), e.y);
                @(negedge clk_i);
                cmp({e.name, " point_o width"}, int'(point_o), 0);
                cmp({e.name, " player_score"}, int'(player_score_o), e.ps);
                cmp({e.name, " pc_score"}, int'(pc_score_o), e.pcs);
                cmp({e.name, " game_over"}, int'(game_over_o), e.go);
                cmp({e.name, " recentred x"}, int'(ball_x_o), 316);
                cmp({e.name, " recentred y"}, int'(ball_y_o), 236);
            end
        end
    end

    initial forever begin
        @(ev_probe);
        while (now_q.size() > 0) cmp_all(now_q.pop_front());
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic frame(input bit st);
        @(negedge clk_i);
        new_frame_i = 1'b1;
        start_i     = st;
        @(negedge clk_i);
        new_frame_i = 1'b0;
        start_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        fnum++;
    endtask

    task automatic fexp(input string name, input int x, input int y, input int ps, input int pcs,
                        input int go, input bit st);
        frame_q.push_back(mk(name, x, y, ps, pcs, go));
        frame(st);
    endtask

    task automatic probe(input string name, input int x, input int y, input int ps, input int pcs,
                         input int go);
        now_q.push_back(mk(name, x, y, ps, pcs, go));
        ->ev_probe;
        #1;
    endtask

    task automatic serve(input string name, input int pcs);
        for (int i = 0; i < 61; i++) fexp(name, 316, 236, 0, pcs, 0, 1'b0);
    endtask

    task automatic play(input int n);
        repeat (n) frame(1'b0);
    endtask

    // Ball leaves the centre going left; odd rounds start with dy down and end at y=392,
    // even rounds start with dy up and end at y=76, both after 79 moves.
    task automatic pc_round(input int r);
        int   y;
        exp_t p;
        y = (r % 2 == 1) ? 392 : 76;
        serve("serve", r - 1);
        if (r == 1) begin
            fexp("first move", 312, 240, 0, 0, 0, 1'b0);
            play(57);
            fexp("bottom bounce", 80, 472, 0, 0, 0, 1'b0);
            fexp("after bounce", 76, 468, 0, 0, 0, 1'b0);
            play(18);
        end else begin
            play(78);
        end
        p = mk("pc point", 0, y, 0, r, (r == 9) ? 1 : 0);
        point_q.push_back(p);
        fexp("pc scoring frame", 0, y, 0, r - 1, 0, 1'b0);
    endtask

    initial begin
        rst_i             = 1'b1;
        new_frame_i       = 1'b0;
        start_i           = 1'b0;
        player_paddle_x_i = 10'd600;
        player_paddle_y_i = 10'd0;
        pc_paddle_x_i     = 10'd0;
        pc_paddle_y_i     = 10'd0;
        #23;
        probe("reset", 316, 236, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        fexp("idle no start", 316, 236, 0, 0, 0, 1'b0);
        fexp("idle no start", 316, 236, 0, 0, 0, 1'b0);
        fexp("start", 316, 236, 0, 0, 0, 1'b1);

        for (int r = 1; r <= 9; r++) pc_round(r);

        for (int i = 0; i < 3; i++) fexp("over hold", 316, 236, 0, 9, 1, 1'b0);
        fexp("restart", 316, 236, 0, 0, 0, 1'b1);

        // Game 2 starts with dy up: k=72 at (28,48), the k=73 move meets the paddle.
        player_paddle_x_i = 10'd16;
        player_paddle_y_i = 10'd20;
        serve("serve2", 0);
        play(72);
        fexp("paddle hit", 24, 52, 0, 0, 0, 1'b0);
        fexp("after paddle hit", 28, 56, 0, 0, 0, 1'b0);

        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        probe("async reset", 316, 236, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) fexp("post reset idle", 316, 236, 0, 0, 0, 1'b0);

        repeat (4) @(negedge clk_i);
        cmp("pending frame expectations", frame_q.size(), 0);
        cmp("pending point expectations", point_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
